// File: rtl/stim_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : stim_pulse_scheduler
// Description : Tick-counted biphasic pulse scheduler (REST/ANO/IPD/CAT) that
//               drives the H-bridge channel selects and current DAC magnitude.
// Revision    : 1.0 - initial release
// ============================================================================
module stim_pulse_scheduler #(
    parameter int CNT_W = 16,
    parameter int MAG_W = 5,
    parameter int NP_W  = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic             STOP,
    input  logic [CNT_W-1:0] T_REST,
    input  logic [CNT_W-1:0] T_ANO,
    input  logic [CNT_W-1:0] T_IPD,
    input  logic [CNT_W-1:0] T_CAT,
    input  logic [2:0]       CH_ANO,
    input  logic [2:0]       CH_CAT,
    input  logic             SWEEP_EN,
    input  logic             RAMP_EN,
    input  logic [MAG_W-1:0] MAG_TGT,
    input  logic [NP_W-1:0]  N_PULSES,
    output logic             EN_ST,
    output logic [MAG_W-1:0] MAG_ST,
    output logic [2:0]       ChSel_HS,
    output logic [2:0]       ChSel_LS,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REST = 3'd1,
        S_ANO  = 3'd2,
        S_IPD  = 3'd3,
        S_CAT  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [MAG_W-1:0] c_mag_one = MAG_W'(1);
    localparam logic [NP_W-1:0]  c_np_one  = NP_W'(1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_timer, w_timer_nxt;
    logic [NP_W-1:0]  r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [1:0]       r_idx, w_idx_nxt;
    logic             r_stop_pend, w_pend_nxt;
    logic [MAG_W-1:0] r_mag, w_mag_nxt;
    logic             w_cap, w_done_nxt, w_en_nxt, w_ramp_step;
    logic [2:0]       w_hs_nxt, w_ls_nxt, w_ano, w_cat;
    logic             r_en, r_busy, r_done;
    logic [2:0]       r_hs, r_ls;

    // Shadow copy of the configuration, frozen for the whole train
    logic [CNT_W-1:0] r_t_rest, r_t_ano, r_t_ipd, r_t_cat;
    logic [2:0]       r_ch_ano, r_ch_cat;
    logic             r_sweep, r_ramp;
    logic [MAG_W-1:0] r_mag_tgt;
    logic [NP_W-1:0]  r_n_pulses;

    // Phase timer load value: a zero duration still lasts one cycle
    function automatic logic [CNT_W-1:0] f_load(input logic [CNT_W-1:0] t);
        return (t == '0) ? '0 : t - c_cnt_one;
    endfunction

    assign w_cnt_inc   = (r_cnt == '1) ? r_cnt : r_cnt + c_np_one;
    assign w_ramp_step = !r_sweep || (r_idx == 2'd3);
    assign w_ano       = r_sweep ? {w_idx_nxt, 1'b0} : r_ch_ano;
    assign w_cat       = r_sweep ? {w_idx_nxt, 1'b1} : r_ch_cat;

    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = (r_timer == '0) ? r_timer : r_timer - c_cnt_one;
        w_cnt_nxt   = r_cnt;
        w_idx_nxt   = r_idx;
        w_pend_nxt  = r_stop_pend;
        w_mag_nxt   = r_mag;
        w_cap       = 1'b0;
        w_done_nxt  = 1'b0;
        w_en_nxt    = 1'b0;
        w_hs_nxt    = 3'd0;
        w_ls_nxt    = 3'd0;

        case (r_state)
            S_IDLE: begin
                if (START && !STOP) begin
                    w_state_nxt = S_REST;
                    w_timer_nxt = f_load(T_REST);
                    w_cnt_nxt   = '0;
                    w_idx_nxt   = 2'd0;
                    w_pend_nxt  = 1'b0;
                    w_mag_nxt   = RAMP_EN ? c_mag_one : MAG_TGT;
                    w_cap       = 1'b1;
                end
            end
            S_REST: begin
                if (STOP) begin
                    w_state_nxt = S_IDLE;
                    w_timer_nxt = '0;
                    w_done_nxt  = 1'b1;
                end else if (r_timer == '0) begin
                    w_state_nxt = S_ANO;
                    w_timer_nxt = f_load(r_t_ano);
                end
            end
            S_ANO: begin
                if (STOP) w_pend_nxt = 1'b1;
                if (r_timer == '0) begin
                    w_state_nxt = S_IPD;
                    w_timer_nxt = f_load(r_t_ipd);
                end
            end
            S_IPD: begin
                if (STOP) w_pend_nxt = 1'b1;
                if (r_timer == '0) begin
                    w_state_nxt = S_CAT;
                    w_timer_nxt = f_load(r_t_cat);
                end
            end
            S_CAT: begin
                if (STOP) w_pend_nxt = 1'b1;
                if (r_timer == '0) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (r_sweep) w_idx_nxt = r_idx + 2'd1;
                    if (r_ramp && w_ramp_step && (r_mag < r_mag_tgt))
                        w_mag_nxt = r_mag + c_mag_one;
                    // A STOP arriving on the final CAT cycle also ends the train
                    if (r_stop_pend || STOP ||
                        ((r_n_pulses != '0) && (w_cnt_inc == r_n_pulses))) begin
                        w_state_nxt = S_IDLE;
                        w_timer_nxt = '0;
                        w_done_nxt  = 1'b1;
                        w_pend_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = S_REST;
                        w_timer_nxt = f_load(r_t_rest);
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_timer_nxt = '0;
            end
        endcase

        case (w_state_nxt)
            S_ANO: begin
                w_en_nxt = 1'b1;
                w_hs_nxt = w_ano;
                w_ls_nxt = w_cat;
            end
            S_IPD: begin
                w_hs_nxt = w_ano;
                w_ls_nxt = w_cat;
            end
            S_CAT: begin
                w_en_nxt = 1'b1;
                w_hs_nxt = w_cat;
                w_ls_nxt = w_ano;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state     <= S_IDLE;
            r_timer     <= '0;
            r_cnt       <= '0;
            r_idx       <= 2'd0;
            r_stop_pend <= 1'b0;
            r_mag       <= '0;
            r_en        <= 1'b0;
            r_hs        <= 3'd0;
            r_ls        <= 3'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_t_rest    <= '0;
            r_t_ano     <= '0;
            r_t_ipd     <= '0;
            r_t_cat     <= '0;
            r_ch_ano    <= 3'd0;
            r_ch_cat    <= 3'd0;
            r_sweep     <= 1'b0;
            r_ramp      <= 1'b0;
            r_mag_tgt   <= '0;
            r_n_pulses  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_stop_pend <= w_pend_nxt;
            r_mag       <= w_mag_nxt;
            r_en        <= w_en_nxt;
            r_hs        <= w_hs_nxt;
            r_ls        <= w_ls_nxt;
            r_busy      <= (w_state_nxt != S_IDLE);
            r_done      <= w_done_nxt;
            if (w_cap) begin
                r_t_rest   <= T_REST;
                r_t_ano    <= T_ANO;
                r_t_ipd    <= T_IPD;
                r_t_cat    <= T_CAT;
                r_ch_ano   <= CH_ANO;
                r_ch_cat   <= CH_CAT;
                r_sweep    <= SWEEP_EN;
                r_ramp     <= RAMP_EN;
                r_mag_tgt  <= MAG_TGT;
                r_n_pulses <= N_PULSES;
            end
        end
    end

    assign EN_ST    = r_en;
    assign MAG_ST   = r_mag;
    assign ChSel_HS = r_hs;
    assign ChSel_LS = r_ls;
    assign BUSY     = r_busy;
    assign DONE     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_stim_pulse_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_stim_pulse_scheduler
// Description : Directed, table-driven bench for stim_pulse_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stim_pulse_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, stop;
    logic [15:0] t_rest, t_ano, t_ipd, t_cat;
    logic [2:0]  ch_ano, ch_cat;
    logic        sweep_en, ramp_en;
    logic [4:0]  mag_tgt;
    logic [7:0]  n_pulses;
    logic        en_st, busy, done;
    logic [4:0]  mag_st;
    logic [2:0]  hs, ls;

    always #5 clk = ~clk;

    stim_pulse_scheduler #(.CNT_W(16), .MAG_W(5), .NP_W(8)) dut (
        .CLK(clk), .RST(rst), .START(start), .STOP(stop),
        .T_REST(t_rest), .T_ANO(t_ano), .T_IPD(t_ipd), .T_CAT(t_cat),
        .CH_ANO(ch_ano), .CH_CAT(ch_cat), .SWEEP_EN(sweep_en), .RAMP_EN(ramp_en),
        .MAG_TGT(mag_tgt), .N_PULSES(n_pulses),
        .EN_ST(en_st), .MAG_ST(mag_st), .ChSel_HS(hs), .ChSel_LS(ls),
        .BUSY(busy), .DONE(done)
    );

    typedef struct {
        int         cyc;
        logic       en;
        logic [4:0] mag;
        logic [2:0] hs;
        logic [2:0] ls;
        logic       busy;
        logic       done;
    } vec_t;

    vec_t tbl[14];
    int   n, n_vec, n_err, en_cnt;

    function automatic int pack(input logic e, input logic [4:0] m, input logic [2:0] h,
                                input logic [2:0] l, input logic b, input logic d);
        return int'({e, m, h, l, b, d});
    endfunction

    function automatic int outs();
        return int'({en_st, mag_st, hs, ls, busy, done});
    endfunction

    function automatic int ebd();
        return int'({en_st, busy, done});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @n=%0d: got 0x%0h expected 0x%0h", name, n, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        n++;
        if (en_st) en_cnt++;
    endtask

    task automatic start_train();
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start  = 1'b0;
        n      = 1;
        en_cnt = en_st ? 1 : 0;
    endtask

    task automatic cfg(input int tr, input int ta, input int ti, input int tc,
                       input int ca, input int cc, input logic sw, input logic rp,
                       input int tg, input int np);
        t_rest = 16'(tr); t_ano = 16'(ta); t_ipd = 16'(ti); t_cat = 16'(tc);
        ch_ano = 3'(ca); ch_cat = 3'(cc); sweep_en = sw; ramp_en = rp;
        mag_tgt = 5'(tg); n_pulses = 8'(np);
    endtask

    function automatic int sweep_mag(input int p);
        return (p < 4) ? 1 : ((p < 8) ? 2 : 3);
    endfunction

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Fixed pair 1/2, 10/5/2/5 ticks, 3 pulses, no ramp
        tbl[0]  = '{1,  1'b0, 5'd31, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[1]  = '{10, 1'b0, 5'd31, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{11, 1'b1, 5'd31, 3'd1, 3'd2, 1'b1, 1'b0};
        tbl[3]  = '{15, 1'b1, 5'd31, 3'd1, 3'd2, 1'b1, 1'b0};
        tbl[4]  = '{16, 1'b0, 5'd31, 3'd1, 3'd2, 1'b1, 1'b0};
        tbl[5]  = '{17, 1'b0, 5'd31, 3'd1, 3'd2, 1'b1, 1'b0};
        tbl[6]  = '{18, 1'b1, 5'd31, 3'd2, 3'd1, 1'b1, 1'b0};
        tbl[7]  = '{22, 1'b1, 5'd31, 3'd2, 3'd1, 1'b1, 1'b0};
        tbl[8]  = '{23, 1'b0, 5'd31, 3'd0, 3'd0, 1'b1, 1'b0};
        tbl[9]  = '{33, 1'b1, 5'd31, 3'd1, 3'd2, 1'b1, 1'b0};
        tbl[10] = '{62, 1'b1, 5'd31, 3'd2, 3'd1, 1'b1, 1'b0};
        tbl[11] = '{66, 1'b1, 5'd31, 3'd2, 3'd1, 1'b1, 1'b0};
        tbl[12] = '{67, 1'b0, 5'd31, 3'd0, 3'd0, 1'b0, 1'b1};
        tbl[13] = '{68, 1'b0, 5'd31, 3'd0, 3'd0, 1'b0, 1'b0};

        n = 0; n_vec = 0; n_err = 0; en_cnt = 0;
        start = 1'b0; stop = 1'b0;
        cfg(0, 0, 0, 0, 0, 0, 1'b0, 1'b0, 0, 0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_state", outs(), 0);
        rst = 1'b0;
        @(negedge clk);

        // Fixed-pair train driven from the vector table
        cfg(10, 5, 2, 5, 1, 2, 1'b0, 1'b0, 31, 3);
        start_train();
        for (int i = 0; i < 70; i++) begin
            if (i > 0) step();
            for (int j = 0; j < 14; j++)
                if (tbl[j].cyc == n)
                    chk($sformatf("fixed_vec%0d", j), outs(),
                        pack(tbl[j].en, tbl[j].mag, tbl[j].hs, tbl[j].ls, tbl[j].busy, tbl[j].done));
        end
        chk("fixed_en_cycles", en_cnt, 30);

        // Sweep with ramp, zero durations (every phase one cycle, period 4)
        cfg(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 3, 0);
        start_train();
        chk("sweep_first_rest", outs(), pack(1'b0, 5'd1, 3'd0, 3'd0, 1'b1, 1'b0));
        while (n < 57) begin
            step();
            if (n >= 2 && ((n - 2) % 4) < 3) begin
                int p, ph, a;
                p  = (n - 2) / 4;
                ph = (n - 2) % 4;
                a  = 2 * (p % 4);
                if (ph == 0)
                    chk($sformatf("sweep_ano_p%0d", p), outs(),
                        pack(1'b1, 5'(sweep_mag(p)), 3'(a), 3'(a + 1), 1'b1, 1'b0));
                else if (ph == 1)
                    chk($sformatf("sweep_ipd_p%0d", p), outs(),
                        pack(1'b0, 5'(sweep_mag(p)), 3'(a), 3'(a + 1), 1'b1, 1'b0));
                else
                    chk($sformatf("sweep_cat_p%0d", p), outs(),
                        pack(1'b1, 5'(sweep_mag(p)), 3'(a + 1), 3'(a), 1'b1, 1'b0));
            end
        end
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("sweep_stop_in_rest", ebd(), 3'b001);
        step();
        chk("sweep_done_one_cycle", ebd(), 3'b000);

        // STOP mid-ANO of pulse 2; START and input changes while busy ignored
        cfg(3, 4, 1, 4, 5, 3, 1'b0, 1'b0, 10, 0);
        start_train();
        for (int i = 1; i < 40; i++) begin
            step();
            if (n == 5) begin start = 1'b1; ch_ano = 3'd7; end
            if (n == 6) begin
                start = 1'b0;
                chk("busy_start_ignored", outs(), pack(1'b1, 5'd10, 3'd5, 3'd3, 1'b1, 1'b0));
            end
            if (n == 17) stop = 1'b1;
            if (n == 18) stop = 1'b0;
            if (n == 24) chk("stop_ano_cat_completes", outs(), pack(1'b1, 5'd10, 3'd3, 3'd5, 1'b1, 1'b0));
            if (n == 25) chk("stop_ano_done", ebd(), 3'b001);
            if (n == 26) chk("stop_ano_idle", ebd(), 3'b000);
        end
        chk("stop_ano_en_cycles", en_cnt, 16);

        // STOP during REST: no pulse at all
        cfg(3, 4, 1, 4, 5, 3, 1'b0, 1'b0, 10, 0);
        start_train();
        step();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("stop_rest_done", ebd(), 3'b001);
        repeat (17) step();
        chk("stop_rest_no_en", en_cnt, 0);

        // START and STOP together in IDLE
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("start_stop_same", ebd(), 3'b000);
        repeat (5) step();
        chk("start_stop_stays_idle", ebd(), 3'b000);

        // Single pulse train
        cfg(2, 2, 2, 2, 1, 2, 1'b0, 1'b0, 7, 1);
        start_train();
        for (int i = 1; i < 20; i++) begin
            step();
            if (n == 8) chk("np1_last_cat", outs(), pack(1'b1, 5'd7, 3'd2, 3'd1, 1'b1, 1'b0));
            if (n == 9) chk("np1_done", ebd(), 3'b001);
        end
        chk("np1_en_cycles", en_cnt, 4);

        // Asynchronous reset mid-CAT, then restart from pair 0 and magnitude 1
        cfg(0, 0, 0, 0, 0, 0, 1'b1, 1'b1, 3, 0);
        start_train();
        while (n < 24) step();
        chk("pre_reset_cat", outs(), pack(1'b1, 5'd2, 3'd3, 3'd2, 1'b1, 1'b0));
        #2 rst = 1'b1;
        #1 chk("async_reset", outs(), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_train();
        chk("restart_rest", outs(), pack(1'b0, 5'd1, 3'd0, 3'd0, 1'b1, 1'b0));
        step();
        chk("restart_ano_pair0", outs(), pack(1'b1, 5'd1, 3'd0, 3'd1, 1'b1, 1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
